// File: rtl/mpu_regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: matrix geometry, the float_sp word,
// and the arbiter's state/owner enums (stands in for mpu_data_types).
package mpu_regfile_write_arbiter_pkg;

   localparam int M     = 6;
   localparam int N     = 6;
   localparam int MBITS = $clog2(M);
   localparam int NBITS = $clog2(N);

   typedef logic [31:0] float_sp;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_LOAD    = 2'd1,
      ARB_GRANT   = 2'd2,
      ARB_COLLECT = 2'd3
   } arbiter_state_e;

   typedef enum logic {
      OWNER_LOADER    = 1'b0,
      OWNER_COLLECTOR = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mpu_regfile_write_arbiter_if.sv
// Bundle of loader, collector and register-file write signals around the arbiter.
// slave = arbiter side, master = requesters / register file side.
interface mpu_regfile_write_arbiter_if;
   import mpu_regfile_write_arbiter_pkg::*;

   logic             load_valid_in;
   logic             load_ready_out;
   logic             load_last_in;
   logic [MBITS:0]   load_i_in;
   logic [NBITS:0]   load_j_in;
   float_sp          load_element_in;

   logic             coll_req_in;
   logic             coll_grant_out;
   logic             coll_active_in;
   logic [MBITS:0]   coll_i_in;
   logic [NBITS:0]   coll_j_in;
   float_sp          coll_element_in;

   logic             reg_write_en_out;
   logic [MBITS:0]   reg_i_out;
   logic [NBITS:0]   reg_j_out;
   float_sp          reg_element_out;
   logic             reg_owner_out;
   logic             arb_error_out;

   modport slave (
      input  load_valid_in, load_last_in, load_i_in, load_j_in, load_element_in,
      input  coll_req_in, coll_active_in, coll_i_in, coll_j_in, coll_element_in,
      output load_ready_out, coll_grant_out,
      output reg_write_en_out, reg_i_out, reg_j_out, reg_element_out, reg_owner_out,
      output arb_error_out
   );

   modport master (
      output load_valid_in, load_last_in, load_i_in, load_j_in, load_element_in,
      output coll_req_in, coll_active_in, coll_i_in, coll_j_in, coll_element_in,
      input  load_ready_out, coll_grant_out,
      input  reg_write_en_out, reg_i_out, reg_j_out, reg_element_out, reg_owner_out,
      input  arb_error_out
   );

endinterface

// File: rtl/mpu_regfile_write_arbiter.sv
// Single write-port arbiter: loader matrices and collector bursts never interleave.
// Optional collector idle watchdog enabled by defining MPU_ARB_WATCHDOG_EN.
module mpu_regfile_write_arbiter
   import mpu_regfile_write_arbiter_pkg::*;
#(
   parameter int BURST_LEN      = M * N,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   mpu_regfile_write_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(BURST_LEN) + 1;

   arbiter_state_e    r_state, w_state_nxt;
   arb_owner_e        r_last_owner, w_last_owner_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

   logic              w_load_acc, w_coll_acc, w_coll_err, w_timeout;
   logic              r_we, r_owner, r_err;
   logic [MBITS:0]    r_i;
   logic [NBITS:0]    r_j;
   float_sp           r_elem;

   assign bus.load_ready_out = (r_state == ARB_LOAD);
   assign bus.coll_grant_out = (r_state == ARB_GRANT);

`ifdef MPU_ARB_WATCHDOG_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0] r_idle;
   logic              w_wd_armed;

   assign w_wd_armed = (r_state == ARB_GRANT) || (r_state == ARB_COLLECT);
   assign w_timeout  = w_wd_armed && !bus.coll_active_in &&
                       (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || !w_wd_armed || bus.coll_active_in || w_timeout) r_idle <= '0;
      else                                                       r_idle <= r_idle + IDLE_W'(1);
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_last_owner_nxt = r_last_owner;
      w_cnt_nxt        = r_cnt;
      w_load_acc       = (r_state == ARB_LOAD) && bus.load_valid_in;
      w_coll_acc       = (r_state == ARB_COLLECT) && bus.coll_active_in;
      w_coll_err       = bus.coll_active_in && (r_state != ARB_COLLECT);

      unique case (r_state)
         ARB_IDLE: begin
            // Tie goes to whoever did not own the port last
            if (bus.coll_req_in && (!bus.load_valid_in || r_last_owner == OWNER_LOADER))
               w_state_nxt = ARB_GRANT;
            else if (bus.load_valid_in)
               w_state_nxt = ARB_LOAD;
         end
         ARB_LOAD: begin
            if (w_load_acc && bus.load_last_in) begin
               w_state_nxt      = ARB_IDLE;
               w_last_owner_nxt = OWNER_LOADER;
            end
         end
         ARB_GRANT: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ARB_COLLECT;
         end
         ARB_COLLECT: begin
            if (w_coll_acc) begin
               if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
                  w_state_nxt      = ARB_IDLE;
                  w_last_owner_nxt = OWNER_COLLECTOR;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase

      if (w_timeout) begin
         w_state_nxt      = ARB_IDLE;
         w_last_owner_nxt = OWNER_COLLECTOR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_last_owner <= OWNER_COLLECTOR;
         r_cnt        <= '0;
         r_err        <= 1'b0;
         r_we         <= 1'b0;
         r_owner      <= 1'b0;
         r_i          <= '0;
         r_j          <= '0;
         r_elem       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_cnt        <= w_cnt_nxt;
         r_err        <= r_err | w_coll_err | w_timeout;
         r_we         <= w_load_acc | w_coll_acc;
         r_owner      <= w_coll_acc;
         if (w_coll_acc) begin
            r_i    <= bus.coll_i_in;
            r_j    <= bus.coll_j_in;
            r_elem <= bus.coll_element_in;
         end else if (w_load_acc) begin
            r_i    <= bus.load_i_in;
            r_j    <= bus.load_j_in;
            r_elem <= bus.load_element_in;
         end else begin
            r_i    <= '0;
            r_j    <= '0;
            r_elem <= '0;
         end
      end
   end

   assign bus.reg_write_en_out = r_we;
   assign bus.reg_owner_out    = r_owner;
   assign bus.reg_i_out        = r_i;
   assign bus.reg_j_out        = r_j;
   assign bus.reg_element_out  = r_elem;
   assign bus.arb_error_out    = r_err;

endmodule

// File: tb/tb_mpu_regfile_write_arbiter.sv
// Directed bench for mpu_regfile_write_arbiter; expectations follow MPU_ARB_WATCHDOG_EN.
module tb_mpu_regfile_write_arbiter;
   import mpu_regfile_write_arbiter_pkg::*;

   localparam int BL = M * N;
   localparam int IW = MBITS + 1;
   localparam int JW = NBITS + 1;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   mpu_regfile_write_arbiter_if bus();

   mpu_regfile_write_arbiter #(.BURST_LEN(BL), .TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL bench_timeout: got still running, want finished");
      $fatal(1, "bench time limit expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load_valid_in   = 1'b0;
      bus.load_last_in    = 1'b0;
      bus.load_i_in       = '0;
      bus.load_j_in       = '0;
      bus.load_element_in = '0;
      bus.coll_req_in     = 1'b0;
      bus.coll_active_in  = 1'b0;
      bus.coll_i_in       = '0;
      bus.coll_j_in       = '0;
      bus.coll_element_in = '0;
   endtask

   // IEEE-754 single encoding of a small non-negative integer
   function automatic logic [31:0] sp_of(input int k);
      int e;
      logic [31:0] man;
      if (k == 0) return 32'h0;
      e = 0;
      for (int b = 0; b < 31; b++) if (k >= (1 << b)) e = b;
      man = (32'(k) << (23 - e)) & 32'h007F_FFFF;
      return {1'b0, 8'(127 + e), man[22:0]};
   endfunction

   task automatic load_matrix(input int req_at);
      for (int k = 0; k < BL; k++) begin
         check($sformatf("ld_ready%0d", k), bus.load_ready_out, 1);
         bus.load_valid_in   = 1'b1;
         bus.load_i_in       = IW'(k / N);
         bus.load_j_in       = JW'(k % N);
         bus.load_element_in = sp_of(k);
         bus.load_last_in    = (k == BL - 1);
         if (k == req_at) bus.coll_req_in = 1'b1;
         step();
         check($sformatf("ld_we%0d", k), bus.reg_write_en_out, 1);
         check($sformatf("ld_own%0d", k), bus.reg_owner_out, 0);
         check($sformatf("ld_i%0d", k), bus.reg_i_out, 64'(k / N));
         check($sformatf("ld_j%0d", k), bus.reg_j_out, 64'(k % N));
         check($sformatf("ld_el%0d", k), bus.reg_element_out, sp_of(k));
         check($sformatf("ld_nogrant%0d", k), bus.coll_grant_out, 0);
      end
      bus.load_valid_in = 1'b0;
      bus.load_last_in  = 1'b0;
      check("ld_done_state", dut.r_state, ARB_IDLE);
      check("ld_done_ready", bus.load_ready_out, 0);
   endtask

   task automatic request_grant();
      bus.coll_req_in = 1'b1;
      step();
      check("grant_hi", bus.coll_grant_out, 1);
      check("grant_noready", bus.load_ready_out, 0);
      bus.coll_req_in = 1'b0;
      step();
      check("grant_pulse", bus.coll_grant_out, 0);
      check("grant_state", dut.r_state, ARB_COLLECT);
   endtask

   task automatic coll_beats(input int n, input int gap_at);
      for (int k = 0; k < n; k++) begin
         if (k == gap_at) begin
            bus.coll_active_in = 1'b0;
            step();
            check("co_gap_we", bus.reg_write_en_out, 0);
         end
         bus.coll_active_in  = 1'b1;
         bus.coll_i_in       = IW'(k / N);
         bus.coll_j_in       = JW'(k % N);
         bus.coll_element_in = 32'h4100_0000 | 32'(k);
         step();
         check($sformatf("co_we%0d", k), bus.reg_write_en_out, 1);
         check($sformatf("co_own%0d", k), bus.reg_owner_out, 1);
         check($sformatf("co_i%0d", k), bus.reg_i_out, 64'(k / N));
         check($sformatf("co_j%0d", k), bus.reg_j_out, 64'(k % N));
         check($sformatf("co_el%0d", k), bus.reg_element_out, 64'(32'h4100_0000 | 32'(k)));
      end
      bus.coll_active_in = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_we", bus.reg_write_en_out, 0);
      check("rst_err", bus.arb_error_out, 0);
      check("rst_ready", bus.load_ready_out, 0);
      check("rst_grant", bus.coll_grant_out, 0);
      check("rst_el", bus.reg_element_out, 0);
      check("rst_own", bus.reg_owner_out, 0);
      check("rst_state", dut.r_state, ARB_IDLE);

      // Loader only
      bus.load_valid_in = 1'b1;
      step();
      check("ld_enter_ready", bus.load_ready_out, 1);
      check("ld_enter_we", bus.reg_write_en_out, 0);
      load_matrix(-1);
      step();
      check("ld_after_we", bus.reg_write_en_out, 0);
      check("ld_after_el", bus.reg_element_out, 0);

      // Collector only, with one gap, then a stray beat
      request_grant();
      coll_beats(BL, 17);
      check("co_done_state", dut.r_state, ARB_IDLE);
      check("co_done_err", bus.arb_error_out, 0);
      bus.coll_active_in = 1'b1;
      step();
      bus.coll_active_in = 1'b0;
      check("stray_we", bus.reg_write_en_out, 0);
      check("stray_err", bus.arb_error_out, 1);
      step();
      check("stray_sticky", bus.arb_error_out, 1);
      check("stray_state", dut.r_state, ARB_IDLE);

      // Tie after reset: loader first, then collector, then loader again
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.load_valid_in = 1'b1;
      bus.coll_req_in   = 1'b1;
      step();
      check("tie1_ready", bus.load_ready_out, 1);
      check("tie1_grant", bus.coll_grant_out, 0);
      load_matrix(-1);
      step();
      check("tie1_coll_grant", bus.coll_grant_out, 1);
      bus.coll_req_in = 1'b0;
      step();
      coll_beats(BL, -1);
      bus.load_valid_in = 1'b1;
      bus.coll_req_in   = 1'b1;
      step();
      check("tie2_ready", bus.load_ready_out, 1);
      check("tie2_grant", bus.coll_grant_out, 0);
      bus.coll_req_in = 1'b0;

      // Request arriving mid-load waits for the loader's last beat
      load_matrix(10);
      step();
      check("midload_grant", bus.coll_grant_out, 1);
      check("midload_we", bus.reg_write_en_out, 0);
      bus.coll_req_in = 1'b0;
      step();
      coll_beats(20, -1);

      // Reset during collector beat 20
      bus.coll_active_in  = 1'b1;
      bus.coll_i_in       = IW'(20 / N);
      bus.coll_j_in       = JW'(20 % N);
      bus.coll_element_in = 32'h4100_0014;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.coll_active_in = 1'b0;
      check("mrst_we", bus.reg_write_en_out, 0);
      check("mrst_el", bus.reg_element_out, 0);
      check("mrst_i", bus.reg_i_out, 0);
      check("mrst_own", bus.reg_owner_out, 0);
      check("mrst_err", bus.arb_error_out, 0);
      check("mrst_grant", bus.coll_grant_out, 0);
      check("mrst_ready", bus.load_ready_out, 0);
      check("mrst_state", dut.r_state, ARB_IDLE);
      request_grant();
      coll_beats(BL, -1);
      check("mrst_done_state", dut.r_state, ARB_IDLE);

      // Collector goes silent after 5 beats
      request_grant();
      coll_beats(5, -1);
      for (int c = 0; c < 15; c++) step();
      check("wd_pre_err", bus.arb_error_out, 0);
      check("wd_pre_state", dut.r_state, ARB_COLLECT);
      step();
`ifdef MPU_ARB_WATCHDOG_EN
      check("wd_err", bus.arb_error_out, 1);
      check("wd_state", dut.r_state, ARB_IDLE);
      bus.coll_req_in = 1'b1;
      step();
      check("wd_regrant", bus.coll_grant_out, 1);
      bus.coll_req_in = 1'b0;
`else
      check("nowd_err", bus.arb_error_out, 0);
      check("nowd_state", dut.r_state, ARB_COLLECT);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
